// File: rtl/uart_word_sender.sv
// Buffers 32-bit result words in a FIFO and sends them on an 8N1 UART line.
// A word goes out as four bytes MSB-first, or as its low byte alone in single mode.
module uart_word_sender #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH_LOG    = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [1:0]  MODE,
   input  logic [31:0] DIN,
   input  logic        WE,
   output logic        READY,
   output logic        TXD,
   output logic        BUSY,
   output logic        OVF
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int BW    = $clog2(CLKS_PER_BIT);
   localparam logic [DEPTH_LOG:0] FULL  = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG:0] CNT1  = (DEPTH_LOG+1)'(1);
   localparam logic [BW-1:0]      LAST  = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

   logic [32:0]          mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [32:0]          hold_q;
   logic                 ready_q, ovf_q, txd_q, txd_d;
   state_e               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           cur_q, cur_d;
   logic [23:0]          rest_q, rest_d;
   logic [1:0]           left_q, left_d;
   logic                 full, accept, pop, tick;
   logic                 unused_mode;

   assign unused_mode = MODE[1];
   assign full   = (count_q == FULL);
   assign accept = WE && !full;
   assign tick   = (baud_q == LAST);

   assign READY = ready_q;
   assign TXD   = txd_q;
   assign OVF   = ovf_q;
   assign BUSY  = (count_q != '0) || (state_q != IDLE);

   always_ff @(posedge CLK) begin
      if (accept) mem_q[wr_ptr_q] <= {MODE[0], DIN};
   end

   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + CNT1;
      else if (!accept && pop) count_d = count_q - CNT1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
         ready_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
         if (pop) begin
            hold_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
         end
         count_q <= count_d;
         ready_q <= (count_d != FULL);
         if (WE && full) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         cur_q   <= '0;
         rest_q  <= '0;
         left_q  <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         cur_q   <= cur_d;
         rest_q  <= rest_d;
         left_q  <= left_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      cur_d   = cur_q;
      rest_d  = rest_q;
      left_d  = left_q;
      baud_d  = '0;
      unique case (state_q)
         IDLE: if (count_q != '0) state_d = LOAD;
         LOAD: begin
            state_d = START;
            if (hold_q[32]) begin
               cur_d  = hold_q[7:0];
               left_d = 2'd0;
            end else begin
               cur_d  = hold_q[31:24];
               rest_d = hold_q[23:0];
               left_d = 2'd3;
            end
         end
         START: if (tick) state_d = DATA;
         DATA: if (tick) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
         end
         STOP: if (tick) begin
            if (left_q != 2'd0) begin
               state_d = START;
               cur_d   = rest_q[23:16];
               rest_d  = {rest_q[15:0], 8'h00};
               left_d  = left_q - 2'd1;
            end else if (count_q != '0) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Counters restart on every state entry, so each bit lasts a full period.
      if (state_d != state_q) bit_d = '0;
      else if (!tick)         baud_d = baud_q + BW'(1);
   end

   always_comb begin
      pop   = 1'b0;
      txd_d = 1'b1;
      if (state_q == IDLE && count_q != '0)
         pop = 1'b1;
      if (state_q == STOP && tick && left_q == 2'd0 && count_q != '0)
         pop = 1'b1;
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = cur_d[bit_d];
         default: txd_d = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench for uart_word_sender: a line monitor decodes frames
// from TXD and each scenario task compares them against expected bytes.
module tb_uart_word_sender;
   localparam int CPB = 4;
   localparam int DL  = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [1:0]  MODE = 2'b00;
   logic [31:0] DIN = '0;
   logic        WE = 1'b0;
   logic        READY, TXD, BUSY, OVF;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   logic [8:0] rx_q[$];
   int         rx_t[$];

   logic       mon_busy = 1'b0;
   logic       mon_ok;
   logic [7:0] mon_byte;
   int         mon_cnt;
   int         mon_t0;

   uart_word_sender #(.CLKS_PER_BIT(CPB), .DEPTH_LOG(DL)) dut (
      .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .DIN(DIN), .WE(WE),
      .READY(READY), .TXD(TXD), .BUSY(BUSY), .OVF(OVF)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Frame decoder: bit k of a frame is sampled 4k+2 negedges after the start edge.
   always @(negedge CLK) begin
      if (!RST_N) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (TXD === 1'b0) begin
            mon_busy = 1'b1;
            mon_cnt  = 0;
            mon_t0   = cyc;
            mon_ok   = 1'b1;
            mon_byte = '0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 2) begin
            if (TXD !== 1'b0) mon_ok = 1'b0;
         end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
            mon_byte[(mon_cnt - 6) / 4] = TXD;
         end else if (mon_cnt == 38) begin
            if (TXD !== 1'b1) mon_ok = 1'b0;
            rx_q.push_back({mon_ok, mon_byte});
            rx_t.push_back(mon_t0);
            mon_busy = 1'b0;
         end
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge CLK);
   endtask

   task automatic push_word(input logic [1:0] m, input logic [31:0] d);
      if (m[0]) begin
         exp_q.push_back(d[7:0]);
      end else begin
         exp_q.push_back(d[31:24]);
         exp_q.push_back(d[23:16]);
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
      end
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge CLK);
         k++;
      end
      n_checks++;
      if (rx_q.size() < n) begin
         n_errors++;
         $display("FAIL %s frames: got %0d want %0d", name, rx_q.size(), n);
      end
   endtask

   task automatic compare_frames(input string name);
      logic [7:0] e;
      logic [8:0] r;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (rx_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s missing: got none want %02h", name, e);
         end else begin
            r = rx_q.pop_front();
            void'(rx_t.pop_front());
            if (r !== {1'b1, e}) begin
               n_errors++;
               $display("FAIL %s byte: got ok=%b %02h want ok=1 %02h",
                        name, r[8], r[7:0], e);
            end
         end
      end
      n_checks++;
      if (rx_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s extra frames: got %0d want 0", name, rx_q.size());
      end
      rx_q.delete();
      rx_t.delete();
   endtask

   task automatic test_reset;
      logic saw_low = 1'b0;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({TXD, READY, BUSY, OVF} !== 4'b1100) begin
         n_errors++;
         $display("FAIL reset outs: got TXD,READY,BUSY,OVF=%b want 1100",
                  {TXD, READY, BUSY, OVF});
      end
      RST_N = 1'b1;
      repeat (100) begin
         @(negedge CLK);
         if (TXD !== 1'b1) saw_low = 1'b1;
      end
      n_checks++;
      if (saw_low || rx_q.size() != 0) begin
         n_errors++;
         $display("FAIL reset idle: got low=%b frames=%0d want 0 0",
                  saw_low, rx_q.size());
      end
   endtask

   task automatic test_word;
      int c0;
      MODE = 2'b00; DIN = 32'h12345678; WE = 1'b1;
      push_word(MODE, DIN);
      @(negedge CLK);
      c0 = cyc;
      WE = 1'b0;
      wait_cyc(c0 + 161);
      n_checks++;
      if (BUSY !== 1'b1) begin
         n_errors++;
         $display("FAIL word busy_in_stop: got %b want 1", BUSY);
      end
      wait_cyc(c0 + 163);
      n_checks++;
      if (BUSY !== 1'b0) begin
         n_errors++;
         $display("FAIL word busy_end: got %b want 0", BUSY);
      end
      wait_frames("word", 4, 50);
      for (int k = 0; k < 4 && k < rx_t.size(); k++) begin
         n_checks++;
         if (rx_t[k] != c0 + 2 + 40 * k) begin
            n_errors++;
            $display("FAIL word start%0d: got %0d want %0d",
                     k, rx_t[k] - c0, 2 + 40 * k);
         end
      end
      compare_frames("word");
   endtask

   task automatic test_single;
      MODE = 2'b01; DIN = 32'hFFFFFFA5; WE = 1'b1;
      push_word(MODE, DIN);
      @(negedge CLK);
      WE = 1'b0;
      wait_frames("single", 1, 100);
      repeat (100) @(negedge CLK);
      compare_frames("single");
   endtask

   task automatic test_overflow;
      MODE = 2'b00; WE = 1'b1;
      for (int i = 0; i < 20; i++) begin
         DIN = 32'(i);
         if (i < 17) push_word(MODE, DIN);
         @(negedge CLK);
         if (i == 15) begin
            n_checks++;
            if (READY !== 1'b1) begin
               n_errors++;
               $display("FAIL ovf ready_e15: got %b want 1", READY);
            end
         end
         if (i == 16) begin
            n_checks++;
            if ({READY, OVF} !== 2'b00) begin
               n_errors++;
               $display("FAIL ovf e16: got READY,OVF=%b want 00", {READY, OVF});
            end
         end
         if (i == 17) begin
            n_checks++;
            if (OVF !== 1'b1) begin
               n_errors++;
               $display("FAIL ovf sticky_e17: got %b want 1", OVF);
            end
         end
      end
      WE = 1'b0;
      wait_frames("ovf", 68, 4000);
      repeat (20) @(negedge CLK);
      n_checks++;
      if ({OVF, READY, BUSY} !== 3'b110) begin
         n_errors++;
         $display("FAIL ovf final: got OVF,READY,BUSY=%b want 110",
                  {OVF, READY, BUSY});
      end
      compare_frames("ovf");
   endtask

   task automatic test_mode_latch;
      MODE = 2'b00; DIN = 32'hA1B2C3D4; WE = 1'b1;
      push_word(MODE, DIN);
      @(negedge CLK);
      MODE = 2'b01; DIN = 32'h11223344;
      push_word(MODE, DIN);
      @(negedge CLK);
      MODE = 2'b10; WE = 1'b0;
      wait_frames("mode", 5, 400);
      repeat (50) @(negedge CLK);
      n_checks++;
      if (rx_t.size() >= 5 && rx_t[4] != rx_t[3] + 41) begin
         n_errors++;
         $display("FAIL mode gap: got %0d want 41", rx_t[4] - rx_t[3]);
      end
      compare_frames("mode");
   endtask

   task automatic test_reset_mid;
      int c0;
      MODE = 2'b00; DIN = 32'h12345678; WE = 1'b1;
      exp_q.push_back(8'h12);
      @(negedge CLK);
      c0 = cyc;
      DIN = 32'hCAFEF00D;
      @(negedge CLK);
      WE = 1'b0;
      wait_cyc(c0 + 59);
      n_checks++;
      if (TXD !== 1'b0) begin
         n_errors++;
         $display("FAIL rstmid pre_txd: got %b want 0", TXD);
      end
      RST_N = 1'b0;
      #1;
      n_checks++;
      if ({TXD, BUSY, READY} !== 3'b101) begin
         n_errors++;
         $display("FAIL rstmid async: got TXD,BUSY,READY=%b want 101",
                  {TXD, BUSY, READY});
      end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (200) @(negedge CLK);
      n_checks++;
      if ({BUSY, TXD} !== 2'b01) begin
         n_errors++;
         $display("FAIL rstmid after: got BUSY,TXD=%b want 01", {BUSY, TXD});
      end
      compare_frames("rstmid");
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_word();
      test_single();
      test_overflow();
      test_mode_latch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_word_sender.md
Name: uart_word_sender

Overview:
- Downstream stage of the TRNG serial-parallel converter. Accepts 32-bit result words on a write strobe and buffers them in a small FIFO.
- Serialises each word to bytes, then transmits them on a UART TXD line (8N1). It drives the READY flag that the converter samples when it drains its accumulators.
- Sits between the converter and the board-level UART pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2.
- DEPTH_LOG, 4, log2 of FIFO depth in words (default depth 16).

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- MODE  input  2  converter mode; sampled with each accepted word
- DIN  input  32  result word from converter
- WE  input  1  write strobe, one word per cycle
- READY  output  1  FIFO not full; feeds converter's UART_READY
- TXD  output  1  UART serial data, idle high
- BUSY  output  1  FIFO non-empty or transmitter not IDLE
- OVF  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous on RST_N low. It forces TXD=1, READY=1, BUSY=0, OVF=0, FIFO empty (count 0), FSM=IDLE and all counters 0. The reset takes effect immediately, including mid-frame, and any partially sent byte is abandoned.
- FIFO entry is 33 bits: {single, DIN}. single = MODE[0] at the write edge.
  - single=0: send 4 bytes, DIN[31:24] first, DIN[7:0] last.
  - single=1: send 1 byte, DIN[7:0].
  - MODE changes affect only later words.
- Write accept: WE=1 and registered count < 2^DEPTH_LOG at that edge. A same-cycle pop does not create room for a write made while full.
  - A dropped write leaves FIFO contents untouched and sets OVF=1. OVF is cleared only by reset.
- Simultaneous accepted write and pop: count unchanged.
- READY is registered and equals (count != 2^DEPTH_LOG). BUSY = (count != 0) or (state != IDLE).
- Transmit FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if count != 0, pop the head entry and go to LOAD.
  - LOAD (1 cycle): latch word and byte count (4 or 1), select first byte, go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, bit index 0..7. After bit 7 go to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles. Then:
    - if bytes remain in the word: go to START with the next byte (no gap);
    - else if count != 0: pop and go to LOAD;
    - else go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles. Inter-word gap: exactly 1 cycle (LOAD), plus the IDLE cycle when the FIFO was empty.
- Latency: for a word written at edge e0 into an empty, idle block, the pop occurs at e1, LOAD occurs at e2, and TXD falls after e2.
- TXD is driven from a register (glitch-free). The baud counter counts 0..CLKS_PER_BIT-1, wraps, and resets on every state entry.
- FIFO pointers are DEPTH_LOG bits and wrap modulo depth. Count is DEPTH_LOG+1 bits.

Test Plan:
- Reset check: assert RST_N=0 for 3 cycles -> TXD=1, READY=1, BUSY=0, OVF=0; after release, with WE idle for 100 cycles, TXD stays 1.
- Word mode, CLKS_PER_BIT=4: MODE=00, DIN=0x12345678, WE for 1 cycle.
  - TXD falls 2 edges later.
  - 4 back-to-back frames 0x12, 0x34, 0x56, 0x78, each 40 cycles, 160 cycles total.
  - BUSY falls 1 cycle after the final stop bit ends.
- Single mode: MODE=01, DIN=0xFFFFFFA5 -> exactly one frame with bits 0 | 1,0,1,0,0,1,0,1 | 1; no further frames.
- Overflow, CLKS_PER_BIT=4, DEPTH_LOG=4: WE=1 for 20 consecutive cycles with DIN=index.
  - 17 words are accepted (one popped at e1) and 3 are dropped.
  - READY=0 from e16; OVF=1 from e17.
  - 17×4 frames are sent with values in order.
- Mode latching: word A with MODE=00, then word B with MODE=01 on the next cycle, then MODE=10 -> 5 frames: A's 4 bytes, then B[7:0]; 1-cycle gap between A's last stop bit and B's start bit.
- Reset mid-frame: pull RST_N low during DATA bit 3 of the second byte -> TXD=1 and BUSY=0 asynchronously; after release the FIFO is empty and no frame is sent.
